// File: rtl/melodia_secuenciador_pkg.sv
// Shared definitions for the melody sequencer: note codes, ROM entry layout,
// FSM state encoding and the note-code to key one-hot decode.
package melodia_secuenciador_pkg;

    localparam int NOTE_W   = 3;
    localparam int DUR_W    = 5;
    localparam int ENTRY_W  = NOTE_W + DUR_W;
    localparam int NOTE_LSB = DUR_W;
    localparam int DUR_LSB  = 0;
    localparam int TECLAS_W = 7;

    localparam logic [NOTE_W-1:0] NOTA_REST = 3'd0;
    localparam logic [NOTE_W-1:0] NOTA_DO   = 3'd1;
    localparam logic [NOTE_W-1:0] NOTA_RE   = 3'd2;
    localparam logic [NOTE_W-1:0] NOTA_MI   = 3'd3;
    localparam logic [NOTE_W-1:0] NOTA_FA   = 3'd4;
    localparam logic [NOTE_W-1:0] NOTA_SOL  = 3'd5;
    localparam logic [NOTE_W-1:0] NOTA_LA   = 3'd6;
    localparam logic [NOTE_W-1:0] NOTA_SI   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_GAP  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Code 0 is a rest (no key); codes 1..7 drive key bit (code-1).
    function automatic logic [TECLAS_W-1:0] decode_nota(input logic [NOTE_W-1:0] code);
        logic [TECLAS_W-1:0] onehot;
        onehot = '0;
        for (int i = 1; i <= TECLAS_W; i++) begin
            if (code == NOTE_W'(i)) onehot[i-1] = 1'b1;
        end
        return onehot;
    endfunction

endpackage

// File: rtl/melodia_secuenciador_rom.sv
// Song storage: combinational case ROM of {note[7:5], duration[4:0]} entries,
// zero-filled past the end-of-song marker.
module melodia_rom
    import melodia_secuenciador_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_entry
);

    function automatic logic [ENTRY_W-1:0] entrada(input logic [NOTE_W-1:0] nota,
                                                   input int unsigned dur);
        return {nota, DUR_W'(dur)};
    endfunction

    always_comb begin
        o_entry = '0;
        case (i_addr)
            ADDR_W'(0): o_entry = entrada(NOTA_DO,   2);
            ADDR_W'(1): o_entry = entrada(NOTA_RE,   2);
            ADDR_W'(2): o_entry = entrada(NOTA_MI,   2);
            ADDR_W'(3): o_entry = entrada(NOTA_FA,   2);
            ADDR_W'(4): o_entry = entrada(NOTA_SOL,  4);
            ADDR_W'(5): o_entry = entrada(NOTA_REST, 2);
            ADDR_W'(6): o_entry = entrada(NOTA_SOL,  4);
            default:    o_entry = '0;
        endcase
    end

endmodule

// File: rtl/melodia_secuenciador.sv
// Automatic melody player driving the note selector's key bus; passes manual keys
// through while idle. Define MELODIA_LOOP_EN to replay the song endlessly.
module melodia_secuenciador
    import melodia_secuenciador_pkg::*;
#(
    parameter int TICK_DIV  = 3125000,
    parameter int GAP_TICKS = 1,
    parameter int SONG_LEN  = 32,
    parameter int ADDR_W    = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic [TECLAS_W-1:0] teclas_manual,
    output logic [TECLAS_W-1:0] teclas,
    output logic                busy,
    output logic [ADDR_W-1:0]   note_idx,
    output logic                done
);

    localparam int                PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(SONG_LEN - 1);
    localparam logic [DUR_W-1:0]  GAP_UNITS = DUR_W'(GAP_TICKS);

    state_t               r_state, w_state_next;
    logic [PRE_W-1:0]     r_pre, w_pre_next;
    logic [DUR_W-1:0]     r_dcnt, w_dcnt_next;
    logic [ADDR_W-1:0]    r_idx, w_idx_next;
    logic [TECLAS_W-1:0]  r_teclas, w_teclas_next;
    logic                 r_busy, r_done;

    logic [ENTRY_W-1:0]   w_entry;
    logic [NOTE_W-1:0]    w_nota;
    logic [DUR_W-1:0]     w_dur;
    logic                 w_tick, w_advance, w_end;

    melodia_rom #(.ADDR_W(ADDR_W)) u_rom (
        .i_addr  (r_idx),
        .o_entry (w_entry)
    );

    assign w_nota = w_entry[NOTE_LSB +: NOTE_W];
    assign w_dur  = w_entry[DUR_LSB  +: DUR_W];
    assign w_tick = (r_pre == PRE_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_pre_next    = r_pre;
        w_dcnt_next   = r_dcnt;
        w_idx_next    = r_idx;
        w_teclas_next = r_teclas;
        w_advance     = 1'b0;
        w_end         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_teclas_next = teclas_manual;
                if (start && !stop) begin
                    w_state_next  = ST_LOAD;
                    w_idx_next    = '0;
                    w_teclas_next = '0;
                end
            end
            ST_LOAD: begin
                w_pre_next = '0;
                if (w_dur == '0) begin
                    w_end = 1'b1;
                end else begin
                    w_teclas_next = decode_nota(w_nota);
                    w_dcnt_next   = w_dur;
                    w_state_next  = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_pre_next = w_tick ? '0 : r_pre + 1'b1;
                if (w_tick) begin
                    if (r_dcnt == DUR_W'(1)) begin
                        w_teclas_next = '0;
                        if (GAP_TICKS > 0) begin
                            w_dcnt_next  = GAP_UNITS;
                            w_state_next = ST_GAP;
                        end else begin
                            w_advance = 1'b1;
                        end
                    end else begin
                        w_dcnt_next = r_dcnt - 1'b1;
                    end
                end
            end
            ST_GAP: begin
                w_pre_next = w_tick ? '0 : r_pre + 1'b1;
                if (w_tick) begin
                    if (r_dcnt == DUR_W'(1)) w_advance = 1'b1;
                    else                     w_dcnt_next = r_dcnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_teclas_next = '0;
                w_state_next  = ST_IDLE;
            end
            default: begin
                w_teclas_next = '0;
                w_state_next  = ST_IDLE;
            end
        endcase

        // Running past the last ROM address counts as the end of the song.
        if (w_advance) begin
            if (r_idx == ADDR_LAST) begin
                w_end = 1'b1;
            end else begin
                w_idx_next   = r_idx + 1'b1;
                w_state_next = ST_LOAD;
            end
        end

        if (w_end) begin
            w_teclas_next = '0;
`ifdef MELODIA_LOOP_EN
            // An end marker at entry 0 would spin forever with no sound, so stop there.
            if (r_state == ST_LOAD && r_idx == '0) begin
                w_state_next = ST_DONE;
            end else begin
                w_idx_next   = '0;
                w_state_next = ST_LOAD;
            end
`else
            w_state_next = ST_DONE;
`endif
        end

        if (stop && r_state != ST_IDLE) begin
            w_teclas_next = '0;
            w_state_next  = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_pre    <= '0;
            r_dcnt   <= '0;
            r_idx    <= '0;
            r_teclas <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_pre    <= w_pre_next;
            r_dcnt   <= w_dcnt_next;
            r_idx    <= w_idx_next;
            r_teclas <= w_teclas_next;
            r_busy   <= (w_state_next != ST_IDLE);
            r_done   <= (w_state_next == ST_DONE);
        end
    end

    assign teclas   = r_teclas;
    assign busy     = r_busy;
    assign note_idx = r_idx;
    assign done     = r_done;

endmodule
